// File: rtl/instruction_fetch.sv
// Fetch stage: reads 16-bit words from synchronous program memory, assembles one/two-word
// AVR instructions, handles skip-next and redirects. Optional counter: FETCH_PERF_COUNT_EN.
module instruction_fetch #(
    parameter int                  PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PC_WIDTH-1:0] progAddr,
    input  logic [15:0]         progData,
    output logic [15:0]         instrWord,
    output logic [15:0]         instrWord2,
    output logic                instrTwoWord,
    output logic [PC_WIDTH-1:0] instrPc,
    output logic                instrValid,
    input  logic                instrReady,
    input  logic                skipReq,
    input  logic                redirectValid,
    input  logic [PC_WIDTH-1:0] redirectPc,
    output logic [31:0]         instrCount
);

    // state  | meaning
    // ISSUE1 | progAddr holds pc, first word being read
    // WAIT1  | first word on progData
    // ISSUE2 | progAddr holds pc+1, second word being read
    // WAIT2  | second word on progData
    // HOLD   | instruction presented, waiting for instrReady
    typedef enum logic [2:0] {ISSUE1, WAIT1, ISSUE2, WAIT2, HOLD} state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);
    localparam logic [PC_WIDTH-1:0] PC_TWO = PC_WIDTH'(2);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]         word_q, word_d;
    logic [15:0]         word2_q, word2_d;
    logic                two_q, two_d;
    logic [PC_WIDTH-1:0] ipc_q, ipc_d;
    logic                valid_q, valid_d;
    logic                skip_q, skip_d;
    logic                is_two_word;
    logic                transfer;

    assign is_two_word = ((progData[15:9] == 7'b1001010) && (progData[3:1] == 3'b110 || progData[3:1] == 3'b111))
                      || ((progData[15:9] == 7'b1001000 || progData[15:9] == 7'b1001001) && progData[3:0] == 4'b0000);
    assign transfer = valid_q && instrReady;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ISSUE1;
            pc_q    <= RESET_VECTOR;
            addr_q  <= RESET_VECTOR;
            word_q  <= '0;
            word2_q <= '0;
            two_q   <= 1'b0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            word2_q <= word2_d;
            two_q   <= two_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        word_d  = word_q;
        word2_d = word2_q;
        two_d   = two_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        skip_d  = skip_q;
        case (state_q)
            ISSUE1: state_d = WAIT1;
            WAIT1: begin
                word_d = progData;
                ipc_d  = pc_q;
                if (is_two_word) begin
                    addr_d  = pc_q + PC_ONE;
                    state_d = ISSUE2;
                end else if (skip_q) begin
                    pc_d    = pc_q + PC_ONE;
                    addr_d  = pc_q + PC_ONE;
                    skip_d  = 1'b0;
                    state_d = ISSUE1;
                end else begin
                    word2_d = '0;
                    two_d   = 1'b0;
                    valid_d = 1'b1;
                    pc_d    = pc_q + PC_ONE;
                    state_d = HOLD;
                end
            end
            ISSUE2: state_d = WAIT2;
            WAIT2: begin
                word2_d = progData;
                pc_d    = pc_q + PC_TWO;
                if (skip_q) begin
                    skip_d  = 1'b0;
                    addr_d  = pc_q + PC_TWO;
                    state_d = ISSUE1;
                end else begin
                    two_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // pc already points past the held instruction
                if (transfer) begin
                    valid_d = 1'b0;
                    addr_d  = pc_q;
                    skip_d  = skipReq;
                    state_d = ISSUE1;
                end
            end
            default: state_d = ISSUE1;
        endcase
        if (redirectValid) begin
            pc_d    = redirectPc;
            addr_d  = redirectPc;
            valid_d = 1'b0;
            skip_d  = 1'b0;
            state_d = ISSUE1;
        end
    end

    assign progAddr     = addr_q;
    assign instrWord    = word_q;
    assign instrWord2   = word2_q;
    assign instrTwoWord = two_q;
    assign instrPc      = ipc_q;
    assign instrValid   = valid_q;

`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] count_q;

    // a transfer coincident with a redirect still counts
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (transfer) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign instrCount = count_q;
`else
    assign instrCount = 32'd0;
`endif

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Reads 16-bit words from synchronous program memory and assembles one- or two-word AVR instructions.
- Presents each instruction with a valid/ready handshake.
- Handles skip-next (cpse and friends) and PC redirects from execute, so the decoder only sees instructions that must execute.

Parameters:
- PC_WIDTH, 16, word-address width of program counter and program memory address.
- RESET_VECTOR, 0, word address fetched first after reset.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- progAddr  output  PC_WIDTH  program memory word address (registered).
- progData  input  16  memory read data; during cycle k+1 it equals mem[progAddr of cycle k].
- instrWord  output  16  first instruction word to the decoder.
- instrWord2  output  16  second word (jmp/call/lds/sts); 0 for one-word instructions.
- instrTwoWord  output  1  presented instruction is two words.
- instrPc  output  PC_WIDTH  address of instrWord.
- instrValid  output  1  presented instruction is valid.
- instrReady  input  1  consumer accepts; transfer occurs when instrValid && instrReady.
- skipReq  input  1  sampled only on transfer: discard the next sequential instruction.
- redirectValid  input  1  load PC from redirectPc; sampled every cycle.
- redirectPc  input  PC_WIDTH  redirect target.
- instrCount  output  32  accepted-instruction count; see Optional Feature.

Behaviour:
- Reset (rst_n=0 at a clock edge) is sole, highest priority:
  - state=ISSUE1, pc=RESET_VECTOR, progAddr=RESET_VECTOR.
  - instrValid=0, instrWord=0, instrWord2=0, instrTwoWord=0, instrPc=0, skipPending=0, instrCount=0.
  - Reset mid-operation discards everything in flight.
- Two-word detect on progData:
  - [15:9]=1001010 and [3:1]=110 or 111 (jmp/call).
  - [15:9]=1001000 or 1001001 and [3:0]=0000 (lds/sts).
- States:
  - ISSUE1: progAddr holds pc → WAIT1.
  - WAIT1: latch instrWord=progData, instrPc=pc.
    - If two-word: progAddr<=pc+1 → ISSUE2.
    - Else if skipPending: pc<=pc+1, progAddr<=pc+1, skipPending<=0 → ISSUE1.
    - Else: instrWord2<=0, instrTwoWord<=0, instrValid<=1, pc<=pc+1 → HOLD.
  - ISSUE2: → WAIT2.
  - WAIT2: latch instrWord2=progData, pc<=pc+2.
    - If skipPending: clear it, progAddr<=pc+2 → ISSUE1 (no valid).
    - Else: instrTwoWord<=1, instrValid<=1 → HOLD.
  - HOLD: instrValid=1; all instr* outputs stable while instrReady=0.
    - On transfer: instrValid<=0, progAddr<=pc, skipPending<=skipReq, instrCount increments → ISSUE1.
- Latency and throughput:
  - First instrValid in the 3rd cycle after reset release.
  - One-word instruction: 3 cycles minimum per transfer.
  - Two-word instruction: 5 cycles minimum per transfer.
- Redirect: if redirectValid (and not reset), it overrides every transition above:
  - pc<=redirectPc, progAddr<=redirectPc, instrValid<=0, skipPending<=0 → ISSUE1.
  - A transfer in the same cycle still counts as accepted.
  - skipReq in that cycle is ignored.
- Skip always discards exactly one instruction, one or two words, using the two-word detect.
- PC arithmetic is modulo 2^PC_WIDTH; pc+1 and pc+2 wrap silently.

Optional Feature:
- Macro FETCH_PERF_COUNT_EN.
- Defined: instrCount is a 32-bit register, reset to 0, incremented on each transfer (including one coincident with redirect), wrapping at 2^32.
- Undefined: instrCount tied to 0; no counter logic.

Test Plan:
1. Reset release, mem[0]=16'hE0A5, instrReady=1 → instrValid high 3rd cycle, instrWord=E0A5, instrPc=0, instrTwoWord=0; next transfer instrPc=1 exactly 3 cycles later.
2. mem[4]=16'h940C, mem[5]=16'h0010 (jmp) → instrTwoWord=1, instrWord2=0010, instrPc=4; following instrPc=6.
3. instrReady=0 for 6 cycles in HOLD → instrValid and all instr* unchanged, progAddr unchanged; no count increment.
4. Transfer at pc=2 with skipReq=1, mem[3]=16'h9100 (lds, two-word) → next valid instrPc=5; words 3 and 4 never presented.
5. redirectValid=1, redirectPc=16'h0020 while in WAIT2 → no valid for the in-flight instruction; next valid instrPc=0020, skipPending cleared.
6. Redirect to 16'hFFFF, one-word instruction there → next instrPc=0000 (wrap); rst_n=0 while in HOLD → instrValid=0 next cycle, fetch restarts at RESET_VECTOR.
